// File: rtl/hdmi_pkg.sv
// Shared TMDS constants, TERC4 table, ones counter and the one-hot period select type.
// Used by the lane encoders and the hdmi_tmds_encoder top.
package hdmi_pkg;

    localparam logic [9:0] CTL_TOKEN [4] = '{
        10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
    };

    localparam logic [9:0] VID_GUARD_CH0 = 10'b1011001100;
    localparam logic [9:0] VID_GUARD_CH1 = 10'b0100110011;
    localparam logic [9:0] VID_GUARD_CH2 = 10'b1011001100;
    localparam logic [9:0] DATA_GUARD    = 10'b0100110011;

    typedef enum logic [6:0] {
        PER_CTL    = 7'b0000001,
        PER_VPRE   = 7'b0000010,
        PER_DPRE   = 7'b0000100,
        PER_VGUARD = 7'b0001000,
        PER_DGUARD = 7'b0010000,
        PER_VIDEO  = 7'b0100000,
        PER_DATA   = 7'b1000000
    } period_t;

    function automatic logic [9:0] terc4(input logic [3:0] nib);
        logic [9:0] sym;
        case (nib)
            4'h0: sym = 10'b1010011100;
            4'h1: sym = 10'b1001100011;
            4'h2: sym = 10'b1011100100;
            4'h3: sym = 10'b1011100010;
            4'h4: sym = 10'b0101110001;
            4'h5: sym = 10'b0100011110;
            4'h6: sym = 10'b0110001110;
            4'h7: sym = 10'b0100111100;
            4'h8: sym = 10'b1011001100;
            4'h9: sym = 10'b0100111001;
            4'hA: sym = 10'b0110011100;
            4'hB: sym = 10'b1011000110;
            4'hC: sym = 10'b1010001110;
            4'hD: sym = 10'b1001110001;
            4'hE: sym = 10'b0101100011;
            default: sym = 10'b1011000011;
        endcase
        return sym;
    endfunction

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/tmds_lane_8b10b.sv
// One TMDS lane: transition-minimising q_m register (stage 1) and DC-balancing disparity stage.
// q is the combinational stage-2 video symbol; en=0 (non-video in stage 1) clears the disparity.
// No backpressure: one symbol per clock.
module tmds_lane_8b10b
    import hdmi_pkg::*;
#(
    parameter int DISP_W = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] d,
    output logic [9:0] q
);

    logic [3:0] n1_d;
    logic       use_xnor;
    logic       acc;
    logic [8:0] qm;
    logic [8:0] qm_r;

    always_comb begin
        n1_d     = ones8(d);
        use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);
        acc      = d[0];
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) begin
            acc   = use_xnor ? ~(acc ^ d[i]) : (acc ^ d[i]);
            qm[i] = acc;
        end
        qm[8] = ~use_xnor;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) qm_r <= '0;
        else       qm_r <= qm;
    end

    logic [3:0]               n1_q;
    logic [3:0]               n0_q;
    logic signed [DISP_W-1:0] diff;
    logic signed [DISP_W-1:0] two_qm8;
    logic signed [DISP_W-1:0] two_nqm8;
    logic signed [DISP_W-1:0] disp;
    logic signed [DISP_W-1:0] disp_nxt;

    always_comb begin
        n1_q     = ones8(qm_r[7:0]);
        n0_q     = 4'd8 - n1_q;
        diff     = DISP_W'({1'b0, n1_q}) - DISP_W'({1'b0, n0_q});
        two_qm8  = DISP_W'({qm_r[8], 1'b0});
        two_nqm8 = DISP_W'({~qm_r[8], 1'b0});
        q        = {1'b0, qm_r[8], qm_r[7:0]};
        disp_nxt = disp;
        if ((disp == '0) || (n1_q == n0_q)) begin
            q        = {~qm_r[8], qm_r[8], qm_r[8] ? qm_r[7:0] : ~qm_r[7:0]};
            disp_nxt = qm_r[8] ? (disp + diff) : (disp - diff);
        end else if ((!disp[DISP_W-1] && (n1_q > n0_q)) || (disp[DISP_W-1] && (n0_q > n1_q))) begin
            // running disparity already leans the same way as this word: invert it
            q        = {1'b1, qm_r[8], ~qm_r[7:0]};
            disp_nxt = disp + two_qm8 - diff;
        end else begin
            disp_nxt = disp - two_nqm8 + diff;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)   disp <= '0;
        else if (en) disp <= disp_nxt;
        else         disp <= '0;
    end

endmodule

// File: rtl/hdmi_tmds_encoder.sv
// Period-flag to TMDS symbol encoder for three lanes (ch0=B, ch1=G, ch2=R); data islands with HDMI_DATA_ISLAND_EN.
// Latency: fixed 2 cycles from inputs to tmds_chN for every period type, sync included.
// No backpressure: one symbol per lane every clock.
module hdmi_tmds_encoder
    import hdmi_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int DISP_W      = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        video_preamble,
    input  logic        video_guard,
    input  logic        video_period,
    input  logic [23:0] video_data,
    input  logic        data_preamble,
    input  logic        data_guard,
    input  logic        data_period,
    input  logic [8:0]  packet_data,
    input  logic        packet_start,
    output logic [9:0]  tmds_ch0,
    output logic [9:0]  tmds_ch1,
    output logic [9:0]  tmds_ch2
);

    if (PIPE_STAGES != 2) begin : g_pipe_check
        $error("hdmi_tmds_encoder: only PIPE_STAGES=2 is supported");
    end

    period_t period_d;
    period_t period_s1;
    logic    hsync_s1;
    logic    vsync_s1;

    always_comb begin
        period_d = PER_CTL;
        if (video_period)        period_d = PER_VIDEO;
        else if (video_guard)    period_d = PER_VGUARD;
`ifdef HDMI_DATA_ISLAND_EN
        else if (data_period)    period_d = PER_DATA;
        else if (data_guard)     period_d = PER_DGUARD;
`endif
        else if (video_preamble) period_d = PER_VPRE;
`ifdef HDMI_DATA_ISLAND_EN
        else if (data_preamble)  period_d = PER_DPRE;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_s1 <= PER_CTL;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
        end else begin
            period_s1 <= period_d;
            hsync_s1  <= hsync;
            vsync_s1  <= vsync;
        end
    end

`ifdef HDMI_DATA_ISLAND_EN
    logic [8:0] packet_s1;
    logic       pstart_s1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            packet_s1 <= '0;
            pstart_s1 <= 1'b0;
        end else begin
            packet_s1 <= packet_data;
            pstart_s1 <= packet_start;
        end
    end
`else
    logic unused_data_island;
    assign unused_data_island = ^{data_preamble, data_guard, data_period, packet_data, packet_start};
`endif

    logic       vid_en;
    logic [9:0] vid_sym [3];

    assign vid_en = (period_s1 == PER_VIDEO);

    for (genvar g = 0; g < 3; g++) begin : g_lane
        tmds_lane_8b10b #(.DISP_W(DISP_W)) u_lane (
            .clock (clock),
            .reset (reset),
            .en    (vid_en),
            .d     (video_data[8*g +: 8]),
            .q     (vid_sym[g])
        );
    end

    logic [9:0] ch0_d;
    logic [9:0] ch1_d;
    logic [9:0] ch2_d;

    always_comb begin
        ch0_d = CTL_TOKEN[{vsync_s1, hsync_s1}];
        ch1_d = CTL_TOKEN[0];
        ch2_d = CTL_TOKEN[0];
        case (period_s1)
            PER_VIDEO: begin
                ch0_d = vid_sym[0];
                ch1_d = vid_sym[1];
                ch2_d = vid_sym[2];
            end
            PER_VGUARD: begin
                ch0_d = VID_GUARD_CH0;
                ch1_d = VID_GUARD_CH1;
                ch2_d = VID_GUARD_CH2;
            end
            // CTL[3:0]=0001: CTL0 set on lane 1
            PER_VPRE: ch1_d = CTL_TOKEN[1];
`ifdef HDMI_DATA_ISLAND_EN
            PER_DPRE: begin
                ch1_d = CTL_TOKEN[1];
                ch2_d = CTL_TOKEN[1];
            end
            PER_DGUARD: begin
                ch0_d = terc4({2'b11, vsync_s1, hsync_s1});
                ch1_d = DATA_GUARD;
                ch2_d = DATA_GUARD;
            end
            PER_DATA: begin
                ch0_d = terc4({~pstart_s1, packet_s1[0], vsync_s1, hsync_s1});
                ch1_d = terc4(packet_s1[4:1]);
                ch2_d = terc4(packet_s1[8:5]);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmds_ch0 <= CTL_TOKEN[0];
            tmds_ch1 <= CTL_TOKEN[0];
            tmds_ch2 <= CTL_TOKEN[0];
        end else begin
            tmds_ch0 <= ch0_d;
            tmds_ch1 <= ch1_d;
            tmds_ch2 <= ch2_d;
        end
    end

endmodule
